fetch_stage: RTL

Instruction-fetch stage of the pipelined ARM core, sitting directly upstream of the instruction memory. It owns the program counter, drives the word address into the instruction memory, and captures the returned word into the IF/ID pipeline register. It also applies the hazard unit's stall and flush controls and the branch/PC-write redirects, and keeps a retired-fetch counter for debug.

---
 rtl/fetch_stage.sv | 75 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents the word address to the
// combinational instruction memory and registers the returned word into IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD,
  output logic [31:0] FetchCount
);

  logic [31:0] pc_next;
  logic [31:0] fetch_count_q;
  logic        capture;

  assign PCPlus4F   = PCF + 32'd4;
  assign PCPlus8D   = PCD + 32'd8;
  assign FetchCount = fetch_count_q;
  assign capture    = !FlushD && !StallD;

  // Redirects outrank StallF so a taken branch is never lost behind a stall.
  always_comb begin
    // NOTE: default assigned first so no path through this block leaves pc_next unassigned (no latch).
    pc_next = PCPlus4F;
    if (BranchTakenE)
      pc_next = BranchTargetE;
    else if (PCSrcW)
      pc_next = ResultW;
    else if (StallF)
      pc_next = PCF;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)
      PCF <= {RESET_PC[31:2], 2'b00};
    else
      PCF <= {pc_next[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD <= NOP_INSTR;
      PCD    <= 32'd0;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      InstrD <= InstrF;
      PCD    <= PCF;
      ValidD <= 1'b1;
    end
  end

  // Counts every real capture, including repeated captures while only StallF is high.
  always_ff @(posedge clk) begin
    if (reset)
      fetch_count_q <= 32'd0;
    else if (capture)
      fetch_count_q <= fetch_count_q + 32'd1;
  end

endmodule
